// File: rtl/round_robin_sel.sv
// Round-robin selector for four sources (a..d) feeding a two-level 2:1 mux tree.
// A grant lasts up to BURST completed beats, or until the granted request drops.
// At release the next winner loads on the same edge, so there is no bubble.
// Optional build macro RR_SEL_LOCK_EN: lock=1 on the burst-end beat extends the grant.
module round_robin_sel #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       lock,
  input  logic       ready,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic [3:0] grant,
  output logic       valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] BurstLast = 4'(BURST - 1);

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel1_q, sel1_d;
  logic       sel2_q, sel2_d;
  logic       sel3_q, sel3_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       beat;
  logic       burst_end;
  logic       lock_hold;
  logic       release_now;

`ifdef RR_SEL_LOCK_EN
  assign lock_hold = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  // grant_q is zero in idle, so valid is low there without a state term.
  assign valid     = |(req & grant_q);
  assign beat      = valid & ready;
  assign burst_end = beat && (cnt_q == BurstLast);

  // Rotating priority search starting just after the most recent grant.
  // last_q always holds the granted index while granting, so the released
  // index is used as the search base without extra muxing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state: load a winner, count beats, release and re-arbitrate.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    sel1_d      = sel1_q;
    sel2_d      = sel2_q;
    sel3_d      = sel3_q;
    release_now = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          grant_d = 4'b0001 << win_idx;
          last_d  = win_idx;
          cnt_d   = 4'd0;
          sel1_d  = (win_idx == 2'd0);
          sel2_d  = (win_idx == 2'd2);
          sel3_d  = ~win_idx[1];
        end
      end
      StGrant: begin
        release_now = !req[last_q] || (burst_end && !lock_hold);
        if (release_now) begin
          if (win_found) begin
            grant_d = 4'b0001 << win_idx;
            last_d  = win_idx;
            cnt_d   = 4'd0;
            sel1_d  = (win_idx == 2'd0);
            sel2_d  = (win_idx == 2'd2);
            sel3_d  = ~win_idx[1];
          end else begin
            state_d = StIdle;
            grant_d = 4'd0;
            cnt_d   = 4'd0;
            sel1_d  = 1'b0;
            sel2_d  = 1'b0;
            sel3_d  = 1'b0;
          end
        end else if (burst_end) begin
          // Locked burst end: keep the grant and start a fresh burst.
          cnt_d = 4'd0;
        end else if (beat) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; last resets to 3 so source a has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 4'd0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      sel3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      sel3_q  <= sel3_d;
    end
  end

  assign grant = grant_q;
  assign sel1  = sel1_q;
  assign sel2  = sel2_q;
  assign sel3  = sel3_q;

endmodule
